one_bit_adder: RTL and testbench
================================

Name: one_bit_adder

Overview:
- Single-bit full adder: sums operand bits a, b and carry-in cin into a 2-bit result {cout, sum}.
- Zero-latency combinational outputs serve as the leaf cell of ripple adders.
- A registered output stage adds a valid flag.
- A carry-feedback register supports bit-serial multi-bit addition, LSB first.

Parameters:
- None. Widths are fixed at one bit per operand.

Ports:
- clk  input  1  rising-edge clock for all registers
- rst_n  input  1  asynchronous active-low reset
- cin  input  1  carry-in, used when serial_en=0 or start=1
- a  input  1  operand bit A
- b  input  1  operand bit B
- cout  output  1  combinational carry-out (result bit 1)
- sum  output  1  combinational sum (result bit 0)
- in_valid  input  1  qualifies a, b, cin for the registered stage and carry update
- serial_en  input  1  1 = carry-in comes from the internal carry register
- start  input  1  first bit of a serial word; forces the external cin
- sum_q  output  1  registered sum
- cout_q  output  1  registered carry-out
- out_valid  output  1  registered result valid

Behaviour:
- Effective carry c_eff:
  - c_eff = cin when serial_en=0, or when serial_en=1 and start=1.
  - Otherwise c_eff = carry_q.
- Combinational path, purely from current inputs:
  - {cout, sum} = a + b + c_eff, 2-bit unsigned, no truncation.
  - sum = a XOR b XOR c_eff.
  - cout = majority(a, b, c_eff).
  - Exhaustive truth table: 000→00, 001→01, 010→01, 011→10, 100→01, 101→10, 110→10, 111→11.
  - Outputs are settled within the same delta/cycle; no clock is needed.
- Registered stage, one-cycle latency:
  - On a rising edge with in_valid=1: sum_q←sum, cout_q←cout, out_valid←1.
  - With in_valid=0: out_valid←0; sum_q and cout_q hold.
- Carry register carry_q:
  - On a rising edge with in_valid=1: carry_q←cout. This update happens regardless of serial_en.
  - With in_valid=0: carry_q holds, so gaps in a serial stream are allowed.
- Reset:
  - While rst_n=0, and immediately on assertion (asynchronous): sum_q=0, cout_q=0, out_valid=0, carry_q=0.
  - Combinational outputs are unaffected by reset.
  - Deassertion is synchronised externally.
- Simultaneous events:
  - start=1 with serial_en=1 and in_valid=1: cin is used, and carry_q is loaded with the new cout in that cycle.
  - start is ignored when serial_en=0.
- Reset mid-serial-word clears carry_q; the next word must begin with start=1.
- Inputs carry no X handling requirement beyond standard propagation.

Optional Feature:
- Macro: ONE_BIT_ADDER_CHECK_EN.
- When defined:
  - Adds output chk_err (1 bit, registered, reset 0).
  - Each in_valid cycle, the gate-level {cout, sum} is compared with an arithmetic reference a+b+c_eff.
  - chk_err is set sticky on mismatch and cleared only by reset.
  - Simulation also issues an assertion failure on mismatch.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package one_bit_adder_pkg holds:
  - typedef add_res_t (2-bit {carry, sum}).
  - Constant ADD_RES_W = 2.
  - Function fa_ref(a, b, c) returning add_res_t, used by both the checker and benches.
- One natural sub-module, fa_cell: the pure combinational full adder (a, b, c → sum, cout).
- The top level adds the carry mux, the output registers and the carry register.

Test Plan:
- Combinational exhaustive, serial_en=0: apply all 8 (a,b,cin) combos, 10 time units each → {cout,sum} equals a+b+cin (e.g. 1,1,1 → 2'b11; 0,1,1 → 2'b10).
- Registered latency: a=1, b=1, cin=0, in_valid=1 for one cycle → next edge sum_q=0, cout_q=1, out_valid=1; following cycle with in_valid=0 → out_valid=0, data held.
- Serial 4-bit add, 11 + 6, LSB first:
  - Stimulus: a bits 1,1,0,1 and b bits 0,1,1,0; start=1 on the first bit with cin=0; serial_en=1, in_valid=1.
  - Required response: sum_q sequence 1,0,0,0 and final cout_q=1 → 17.
- Gap tolerance: the same serial word with in_valid=0 bubbles between bits → identical result, with carry_q held across bubbles.
- Async reset mid-word: assert rst_n=0 between clock edges after bit 2 → sum_q, cout_q, out_valid and carry_q read 0 immediately; combinational sum still tracks the inputs.
- With ONE_BIT_ADDER_CHECK_EN: run all 8 combos → chk_err stays 0; force an internal fault on sum → chk_err=1 one cycle later and stays 1 until reset.

Source files
------------

// File: rtl/one_bit_adder_pkg.sv
// -----------------------------------------------------------------------------
// one_bit_adder_pkg
//
// Shared types and helpers for the one-bit full adder and its benches.
//   ADD_RES_W : width of a full-adder result, {carry, sum}
//   add_res_t : packed {carry, sum} result
//   fa_ref()  : arithmetic reference model of a full adder. It uses an
//               integer add on purpose, so it is independent of the
//               gate-level cell it is compared against.
// -----------------------------------------------------------------------------
package one_bit_adder_pkg;

  localparam int ADD_RES_W = 2;

  typedef struct packed {
    logic carry;
    logic sum;
  } add_res_t;

  function automatic add_res_t fa_ref(input logic a, input logic b, input logic c);
    logic [ADD_RES_W-1:0] total;
    total = {1'b0, a} + {1'b0, b} + {1'b0, c};
    return add_res_t'(total);
  endfunction

endpackage : one_bit_adder_pkg

// File: rtl/one_bit_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//
// Pure combinational gate-level full adder. This is the leaf cell of a
// ripple-carry chain.
//   a, b : operand bits
//   c    : carry-in
//   sum  : a ^ b ^ c
//   cout : majority(a, b, c)
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  logic prop;  // carry propagate: a carry-in passes straight through
  logic gen;   // carry generate: a carry-out regardless of the carry-in

  assign prop = a ^ b;
  assign gen  = a & b;

  assign sum  = prop ^ c;
  assign cout = gen | (prop & c);

endmodule : fa_cell

// File: rtl/one_bit_adder.sv
// -----------------------------------------------------------------------------
// one_bit_adder
//
// Single-bit full adder with a combinational path, a registered output
// stage and a carry-feedback register. The feedback register supports
// bit-serial multi-bit addition, least significant bit first.
//
// Ports
//   clk        : rising-edge clock for all registers
//   rst_n      : asynchronous active-low reset; clears all registers
//   a, b       : operand bits
//   cin        : external carry-in, used when serial_en=0 or start=1
//   in_valid   : qualifies the inputs for the output and carry registers
//   serial_en  : 1 = carry-in comes from the internal carry register
//   start      : first bit of a serial word; forces the external cin
//   sum, cout  : combinational result; reset does not affect it
//   sum_q      : registered sum
//   cout_q     : registered carry-out
//   out_valid  : registered result valid
//   chk_err    : sticky self-check error (only with ONE_BIT_ADDER_CHECK_EN)
//
// Build option
//   ONE_BIT_ADDER_CHECK_EN : when defined, adds the chk_err port. On every
//   in_valid cycle the gate-level result is compared against fa_ref(), and a
//   simulation assertion fires on any mismatch.
// -----------------------------------------------------------------------------
module one_bit_adder
  import one_bit_adder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic cout,
  output logic sum,
  input  logic in_valid,
  input  logic serial_en,
  input  logic start,
  output logic sum_q,
  output logic cout_q,
  output logic out_valid
`ifdef ONE_BIT_ADDER_CHECK_EN
  ,
  output logic chk_err
`endif
);

  logic     carry_q;
  logic     c_eff;
  add_res_t res_gate;
  add_res_t res_q;
  logic     valid_q;

  // ---------------------------------------------------------------------------
  // Carry select. A serial word continues from the stored carry. The first
  // bit of the word (start=1) and all non-serial use take the external cin.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so that no path
  // leaves the output unassigned and infers a latch.
  always_comb begin
    c_eff = cin;
    if (serial_en && !start) begin
      c_eff = carry_q;
    end
  end

  fa_cell u_fa_cell (
    .a    (a),
    .b    (b),
    .c    (c_eff),
    .sum  (res_gate.sum),
    .cout (res_gate.carry)
  );

  assign sum  = res_gate.sum;
  assign cout = res_gate.carry;

  // ---------------------------------------------------------------------------
  // Output stage and carry register. Both hold through in_valid=0 bubbles, so
  // a serial stream may have gaps. The carry updates on every valid cycle,
  // whatever serial_en is, so it always holds the most recent carry-out.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register here
  // is a flop with a defined reset value; none of them is a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q   <= res_gate;
        carry_q <= res_gate.carry;
      end
    end
  end

  assign sum_q     = res_q.sum;
  assign cout_q    = res_q.carry;
  assign out_valid = valid_q;

`ifdef ONE_BIT_ADDER_CHECK_EN
  // ---------------------------------------------------------------------------
  // Self-check. The arithmetic reference uses the same effective carry, so
  // only a fault in the gate-level cell or its wiring can cause a mismatch.
  // Once set, the error stays set until reset.
  // ---------------------------------------------------------------------------
  add_res_t res_ref;
  logic     mismatch;

  assign res_ref  = fa_ref(a, b, c_eff);
  assign mismatch = in_valid && (res_gate != res_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (mismatch) begin
      chk_err <= 1'b1;
    end
  end

  a_gate_matches_ref : assert property (
    @(posedge clk) disable iff (!rst_n) in_valid |-> (res_gate == res_ref)
  );
`endif

endmodule : one_bit_adder

// File: tb/tb_one_bit_adder.sv
// -----------------------------------------------------------------------------
// tb_one_bit_adder
//
// Directed testbench for one_bit_adder. Expected values are hand-computed.
// The bench drives inputs on the falling clock edge and samples the
// registered outputs at the next falling edge. The internal carry register
// is observed through the combinational path: with serial_en=1, start=0 and
// a=b=0, the sum equals carry_q.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_one_bit_adder;

  logic clk;
  logic rst_n;
  logic cin, a, b;
  logic cout, sum;
  logic in_valid, serial_en, start;
  logic sum_q, cout_q, out_valid;
`ifdef ONE_BIT_ADDER_CHECK_EN
  logic chk_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  one_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .cout      (cout),
    .sum       (sum),
    .in_valid  (in_valid),
    .serial_en (serial_en),
    .start     (start),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
`ifdef ONE_BIT_ADDER_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Hand-computed {cout, sum} for index {a, b, cin}.
  logic [1:0] truth [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  // 11 + 6, LSB first: a = 1011, b = 0110, sum bits 1,0,0,0, carry-out 1 (= 17).
  logic [3:0] ser_a   = 4'b1011;
  logic [3:0] ser_b   = 4'b0110;
  logic [3:0] ser_sum = 4'b0001;

  // Drives one serial word on the falling edge. cin is 0 on the start bit
  // and 1 on every later bit, which shows that cin is ignored mid-word.
  // Optional in_valid=0 bubbles are inserted between the bits.
  task automatic serial_word(input bit gaps, input string name);
    for (int i = 0; i < 4; i++) begin
      a         = ser_a[i];
      b         = ser_b[i];
      cin       = (i == 0) ? 1'b0 : 1'b1;
      serial_en = 1'b1;
      start     = (i == 0);
      in_valid  = 1'b1;
      @(negedge clk);
      check($sformatf("%s bit%0d sum_q", name, i), sum_q, ser_sum[i]);
      check($sformatf("%s bit%0d out_valid", name, i), out_valid, 1'b1);
      if (gaps) begin
        in_valid = 1'b0;
        start    = 1'b0;
        a        = ~a;
        b        = 1'b1;
        cin      = 1'b0;
        @(negedge clk);
        check($sformatf("%s gap%0d out_valid", name, i), out_valid, 1'b0);
        check($sformatf("%s gap%0d sum_q held", name, i), sum_q, ser_sum[i]);
      end
    end
    check({name, " final cout_q"}, cout_q, 1'b1);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    in_valid = 1'b0; serial_en = 1'b0; start = 1'b0;

    // Reset state.
    #3;
    check("rst sum_q", sum_q, 1'b0);
    check("rst cout_q", cout_q, 1'b0);
    check("rst out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive combinational check, serial_en=0.
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #10;
      check($sformatf("comb abc=%0d", i), {cout, sum}, truth[i]);
    end
    check("comb no out_valid", out_valid, 1'b0);

    // Registered latency: 1 + 1 + 0.
    @(negedge clk);
    a = 1'b1; b = 1'b1; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("reg sum_q", sum_q, 1'b0);
    check("reg cout_q", cout_q, 1'b1);
    check("reg out_valid", out_valid, 1'b1);
    in_valid = 1'b0; a = 1'b0; b = 1'b1;
    @(negedge clk);
    check("hold out_valid", out_valid, 1'b0);
    check("hold sum_q", sum_q, 1'b0);
    check("hold cout_q", cout_q, 1'b1);

    // carry_q is now 1. start=1 must still force cin=0.
    serial_word(1'b0, "ser");

    // carry_q = 1. It feeds the adder only with serial_en=1 and start=0.
    a = 1'b0; b = 1'b0; cin = 1'b0; serial_en = 1'b1; start = 1'b0;
    #1 check("carry_q feeds sum", sum, 1'b1);
    serial_en = 1'b0; start = 1'b1;
    #1 check("start ignored, serial_en=0", sum, 1'b0);
    start = 1'b0;
    @(negedge clk);

    serial_word(1'b1, "gap");

    // Reset in the middle of a word, after two bits.
    for (int i = 0; i < 2; i++) begin
      a = ser_a[i]; b = ser_b[i]; cin = 1'b0;
      serial_en = 1'b1; start = (i == 0); in_valid = 1'b1;
      @(negedge clk);
    end
    check("pre-rst cout_q", cout_q, 1'b1);
    in_valid = 1'b0; start = 1'b0; a = 1'b0; b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst sum_q", sum_q, 1'b0);
    check("async rst cout_q", cout_q, 1'b0);
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst carry_q", sum, 1'b0);
    a = 1'b1;
    #1 check("comb during rst sum", {cout, sum}, 2'b01);
    a = 1'b1; b = 1'b1; serial_en = 1'b0; cin = 1'b1;
    #1 check("comb during rst 111", {cout, sum}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    serial_en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;

`ifdef ONE_BIT_ADDER_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("chk_err clean", chk_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected done by 50000");
    $fatal(1);
  end

endmodule : tb_one_bit_adder
